// File: rtl/serial_sub_32_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, default width and the overflow helper.
package serial_sub_32_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Signed overflow of a - b from the three sign bits.
    function automatic logic sub_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_sub_32_if.sv
// Request/result bundle of the bit-serial subtractor.
// master: start, a, b out; slave: busy, done, diff, borrow, overflow, zero out.
interface serial_sub_32_if
    import serial_sub_32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow, zero
    );

endinterface

// File: rtl/serial_sub_32_full_subtractor.sv
// One-bit full subtractor built from gate primitives.
// Ports: a, b, i_borrow in; o_diff, o_borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic i_borrow,
    output logic o_diff,
    output logic o_borrow
);

    logic ab_x;
    logic a_n;
    logic ab_xn;
    logic gen;
    logic prop;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (o_diff, ab_x, i_borrow);
    not g_n0 (a_n, a);
    not g_n1 (ab_xn, ab_x);
    and g_a0 (gen, a_n, b);
    and g_a1 (prop, ab_xn, i_borrow);
    or  g_o0 (o_borrow, gen, prop);

endmodule

// File: rtl/serial_sub_32.sv
// Bit-serial a - b, LSB first, one bit per clock through one full subtractor.
// Ports: clk, rst (sync, active high), bus (serial_sub_32_if.slave).
// Build option: define SERIAL_SUB_FLAGS_EN to compute overflow and zero.
module serial_sub_32
    import serial_sub_32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic            clk,
    input logic            rst,
    serial_sub_32_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] d_q;
    logic             bw_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             d_bit;
    logic             bw_bit;
    logic [WIDTH-1:0] d_nxt;
    logic             last;
    logic             accept;
    logic             shifting;
    logic             busy_c;
    logic             done_c;

    full_subtractor u_fs (
        .a        (a_q[0]),
        .b        (b_q[0]),
        .i_borrow (bw_q),
        .o_diff   (d_bit),
        .o_borrow (bw_bit)
    );

    assign shifting = (state_q == SHIFT);
    assign last     = (cnt_q == CW'(WIDTH - 1));
    assign accept   = bus.start &&
                      ((state_q == IDLE) || (state_q == DONE));
    // New bit enters at the MSB; after WIDTH shifts it sits at bit 0.
    assign d_nxt    = {d_bit, d_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = bus.start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        unique case (state_q)
            SHIFT:   busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            bw_q  <= 1'b0;
            cnt_q <= '0;
        end else if (shifting) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            d_q   <= d_nxt[WIDTH-1:1];
            bw_q  <= bw_bit;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                diff_q   <= d_nxt;
                borrow_q <= bw_bit;
            end
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // On the last bit a_q[0]/b_q[0] hold the original sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!accept && shifting && last) begin
            ovf_q  <= sub_overflow(a_q[0], b_q[0], d_bit);
            zero_q <= (d_nxt == '0);
        end
    end

    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
`else
    assign bus.overflow = 1'b0;
    assign bus.zero     = 1'b0;
`endif

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_32.sv
// Directed bench for serial_sub_32 with an arithmetic reference model.
// Start presented in cycle 0 must show done in cycle WIDTH+1.
module tb_serial_sub_32;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    serial_sub_32_if #(.WIDTH(W)) bus ();

    serial_sub_32 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    bit          m_valid = 1'b0;
    int          m_left  = 0;
    logic        m_busy, m_done;
    logic [W-1:0] m_diff;
    logic        m_borrow, m_ovf, m_zero;
    logic [W-1:0] p_diff;
    logic        p_borrow, p_ovf, p_zero;

    // Model: an accepted job completes W edges later with plain arithmetic.
    always @(posedge clk) begin
        longint sa, sb, r;
        if (rst) begin
            m_left   = 0;
            m_done   = 1'b0;
            m_diff   = '0;
            m_borrow = 1'b0;
            m_ovf    = 1'b0;
            m_zero   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done   = 1'b1;
                    m_diff   = p_diff;
                    m_borrow = p_borrow;
                    m_ovf    = p_ovf;
                    m_zero   = p_zero;
                end
            end else if (bus.start) begin
                p_diff   = bus.a - bus.b;
                p_borrow = (bus.a < bus.b);
                sa = longint'($signed(bus.a));
                sb = longint'($signed(bus.b));
                r  = sa - sb;
`ifdef SERIAL_SUB_FLAGS_EN
                p_ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                p_zero = (p_diff == '0);
`else
                p_ovf  = 1'b0;
                p_zero = 1'b0;
`endif
                m_left = W;
            end
        end
        m_busy  = (m_left > 0);
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 64'(bus.busy), 64'(m_busy));
            check("done", 64'(bus.done), 64'(m_done));
            check("diff", 64'(bus.diff), 64'(m_diff));
            check("borrow", 64'(bus.borrow), 64'(m_borrow));
            check("overflow", 64'(bus.overflow), 64'(m_ovf));
            check("zero", 64'(bus.zero), 64'(m_zero));
        end
    end

    task automatic run_op(input logic [W-1:0] ta,
                          input logic [W-1:0] tb,
                          input logic [W-1:0] ed,
                          input logic eb,
                          input logic eo,
                          input logic ez,
                          input bit   tog);
        int cyc;
        int extra;
        bus.a     = ta;
        bus.b     = tb;
        bus.start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (tog && !bus.done) begin
                bus.start = 1'($urandom);
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
        end while (!bus.done && cyc < 100);
        bus.start = 1'b0;
        check("latency", 64'(cyc), 64'(W + 1));
        check("lit_diff", 64'(bus.diff), 64'(ed));
        check("lit_borrow", 64'(bus.borrow), 64'(eb));
`ifdef SERIAL_SUB_FLAGS_EN
        check("lit_overflow", 64'(bus.overflow), 64'(eo));
        check("lit_zero", 64'(bus.zero), 64'(ez));
`else
        check("lit_overflow", 64'(bus.overflow), 64'(1'b0 & eo));
        check("lit_zero", 64'(bus.zero), 64'(1'b0 & ez));
`endif
        if (tog) begin
            extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            check("done_once", 64'(extra), 64'(0));
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_diff", 64'(bus.diff), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd10, 32'd3, 32'd7, 0, 0, 0, 0);
        run_op(32'd3, 32'd10, 32'hFFFF_FFF9, 1, 0, 0, 0);
        run_op(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 0, 0);
        run_op(32'd5, 32'd5, 32'd0, 0, 0, 1, 0);
        @(negedge clk);
        run_op(32'd0, 32'd1, 32'hFFFF_FFFF, 1, 0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0, 1, 0);
        run_op(32'd0, 32'd0, 32'd0, 0, 0, 1, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 0, 0);
        run_op(32'd1234, 32'd0, 32'd1234, 0, 0, 0, 0);
        @(negedge clk);
        run_op(32'd10, 32'd3, 32'd7, 0, 0, 0, 1);

        bus.a     = 32'h1234_5678;
        bus.b     = 32'h0000_0001;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 64'(bus.busy), 64'(0));
        check("rst_mid_done", 64'(bus.done), 64'(0));
        check("rst_mid_diff", 64'(bus.diff), 64'(0));
        check("rst_mid_borrow", 64'(bus.borrow), 64'(0));
        bus.start = 1'b1;
        @(negedge clk);
        check("rst_prio_busy", 64'(bus.busy), 64'(0));
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 64'(bus.busy), 64'(0));
        run_op(32'd100, 32'd42, 32'd58, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
